// File: rtl/slow_clk_pkg.sv
// Shared definitions for the slow clock meter.
//   state_e          : measurement FSM state (IDLE, MEASURE)
//   CNT_W_DEF        : default period counter width in bits
//   TIMEOUT_CYC_DEF  : default cycles without a rise before a timeout
package slow_clk_pkg;

    localparam int          CNT_W_DEF       = 24;
    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'hFFFFFF;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/sync_rise_det.sv
// Synchronizes an asynchronous input into the clk domain and flags its rising
// edges.
//   clk      : system clock, all flops on posedge
//   reset    : synchronous, active-high
//   async_in : input asynchronous to clk
//   rise     : registered one-cycle strobe per synchronized rising edge
module sync_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic rise_q, rise_d;

    always_comb begin
        s1_d   = async_in;
        s2_d   = s1_q;
        // s3 is the delayed copy used only for edge detection.
        s3_d   = s2_q;
        rise_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/slow_clk_meter.sv
// Measures the period of a slow, asynchronous signal in clk cycles.
//   clk          : system clock
//   reset        : synchronous, active-high
//   sig_in       : slow clock / tick to measure (asynchronous)
//   rise_pulse   : one-cycle strobe per detected rising edge of sig_in
//   period       : last accepted measurement
//   period_valid : period holds an unconsumed measurement
//   period_ready : consumer accepts period when high with period_valid
//   timeout      : sticky, a measurement window expired
//   overrun      : sticky, a measurement was dropped
// Output handshake: a measurement transfers on any cycle where period_valid
// and period_ready are both high; period is stable while valid waits.
module slow_clk_meter
    import slow_clk_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(TIMEOUT_CYC_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             timeout,
    output logic             overrun
);

    logic rise;

    sync_rise_det u_sync_rise_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (sig_in),
        .rise     (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             capture;

    // Measurement FSM and counter. A rise always wins over the timeout
    // check, so the largest period ever captured is TIMEOUT_CYC and the
    // counter cannot wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TIMEOUT_CYC) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register. A capture replaces the held value only when the slot
    // is empty or being drained this cycle; otherwise it is dropped.
    always_comb begin
        rise_pulse_d   = rise;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        overrun_d      = overrun_q;
        if (capture) begin
            if (!period_valid_q || period_ready) begin
                period_d       = cnt_q;
                period_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (period_valid_q && period_ready) begin
            period_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rise_pulse_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rise_pulse_q   <= rise_pulse_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rise_pulse   = rise_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/slow_clk_meter.md
SLOW_CLK_METER -- requirements
Module: slow_clk_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24, giving the period counter width in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 24'hFFFFFF, giving the cycles without a rising edge before a timeout; legal range 2 to 2^CNT_W-1.
REQ-003 clk  input  1  single system clock; all flops on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  slow clock or tick to be measured; asynchronous to clk.
REQ-006 rise_pulse  output  1  one-cycle strobe per detected sig_in rising edge.
REQ-007 period  output  CNT_W  last measured period, in clk cycles.
REQ-008 period_valid  output  1  period holds an unconsumed measurement.
REQ-009 period_ready  input  1  consumer accepts period when it is high together with period_valid.
REQ-010 timeout  output  1  sticky flag: a measurement window expired.
REQ-011 overrun  output  1  sticky flag: a measurement was dropped.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer, then a third flop used for edge detection.
REQ-013 rise_pulse SHALL be registered and high for exactly one cycle, 3 cycles after the first clk edge that samples sig_in high.
REQ-014 The FSM SHALL have states IDLE and MEASURE.
REQ-015 IDLE: on a detected rise, the FSM SHALL load cnt=1 and move to MEASURE; no measurement is produced.
REQ-016 MEASURE: cnt SHALL increment by 1 each cycle without a rise, so that rises N cycles apart capture period=N.
REQ-017 MEASURE, on a rise: the block SHALL capture cnt as the new measurement, reload cnt=1 and stay in MEASURE.
REQ-018 MEASURE, when cnt==TIMEOUT_CYC with no rise in that cycle: the block SHALL set timeout, go to IDLE and produce no measurement.
REQ-019 A rise in the same cycle as cnt==TIMEOUT_CYC SHALL take priority, so the capture happens and no timeout is flagged.
REQ-020 cnt SHALL never wrap, because the timeout always fires first.
REQ-021 On capture with period_valid=0, the block SHALL load period and set period_valid in the next cycle.
REQ-022 On capture with period_valid=1 and period_ready=1 in the same cycle, the block SHALL load the new period and keep period_valid=1.
REQ-023 On capture with period_valid=1 and period_ready=0, the block SHALL drop the new value, leave period unchanged and set overrun.
REQ-024 When period_valid=1, period_ready=1 and there is no capture, period_valid SHALL clear in the next cycle; period SHALL hold its value.
REQ-025 period SHALL stay stable while period_valid=1 and period_ready=0.
REQ-026 timeout and overrun SHALL be cleared only by reset.

Reset
REQ-027 When reset=1 at a clk edge, the block SHALL enter IDLE with cnt=0, all synchronizer/edge flops=0, rise_pulse=0, period=0, period_valid=0, timeout=0 and overrun=0.
REQ-028 Reset SHALL take priority over every event, including a rise or capture in the same cycle.
REQ-029 A reset during MEASURE SHALL discard the partial count; after release, the first rise only re-arms the FSM.
REQ-030 Because the edge flops clear to 0, an input that is high at reset release SHALL produce one rise_pulse and re-arm the FSM.

Structure
REQ-031 Package slow_clk_pkg SHALL hold the FSM state enum (IDLE, MEASURE) and the default CNT_W/TIMEOUT_CYC constants.
REQ-032 The synchronizer plus edge detector SHALL be sub-module sync_rise_det (inputs clk, reset, async_in; output rise).
REQ-033 Counter, FSM and output register SHALL live in slow_clk_meter.

Verification
REQ-034 Reset, then sig_in square wave with period 10 clk (5 high/5 low), period_ready=1: the first rise gives no output; every following rise gives period=10 with a 1-cycle period_valid; timeout=0 and overrun=0.
REQ-035 TIMEOUT_CYC=50, one rise then sig_in held low: timeout=1 when cnt reaches 50, FSM in IDLE, period_valid stays 0; the next two rises 20 apart give period=20.
REQ-036 Period 8 with period_ready=0: the first capture gives period=8 held stable; the second capture sets overrun=1 and period stays 8; raising period_ready gives one handshake and then period_valid=0.
REQ-037 period_ready pulsed in exactly the capture cycle while period_valid=1: the new value loads and period_valid stays 1 with no gap; overrun=0.
REQ-038 Reset asserted 5 cycles into a period-12 measurement: all outputs return to their reset values; after release, the first rise re-arms only and the next rise reports 12.
REQ-039 sig_in rises at a known cycle: rise_pulse is high exactly 3 cycles later for 1 cycle; a 1-cycle-wide high pulse on sig_in still gives exactly one rise_pulse.
